bcd_counter_ndigit: RTL and testbench
=====================================

Name: bcd_counter_ndigit

Overview:
- Parametrised multi-digit BCD counter: DIGITS cascaded decade stages, each 0..9.
- Adds count enable, up/down direction, parallel load with digit validation, and a terminal-count wrap pulse.
- All outputs are registered.
- Drop-in building block for timers, display drivers and event tallies. It is the generalised successor to the team's single-digit decade counter.

Parameters:
- DIGITS, 4, number of BCD digits (>=1). Counter range is 0 .. 10^DIGITS-1.

Ports:
- clock  in  1  rising-edge clock for all state.
- clear  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per clock while high.
- up_dn  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- count  out  4*DIGITS  current BCD count, same packing as load_val.
- wrap  out  1  one-cycle pulse, high in the cycle count shows a wrapped value.
- load_err  out  1  sticky flag: a loaded digit was greater than 9.

Behaviour:
- All state changes on the rising edge of clock.
- Synchronous, active-high reset only. There is no asynchronous path.
- Priority per cycle: clear > load > en. When none of these is active, state holds.

Reset (clear=1):
- count = 0, wrap = 0, load_err = 0.
- Takes effect at the next edge regardless of load or en.
- Mid-count clear discards the count.

Load (load=1, clear=0):
- count <= load_val on the edge, digit by digit.
- Any digit > 9 (4'hA..4'hF) is written as 0 and sets load_err. load_err stays 1 until clear.
- en is ignored in a load cycle. wrap = 0.

Count (en=1, load=0, clear=0):
Up (up_dn=1):
- Digit 0 increments.
- A digit at 9 becomes 0 and carries into the next digit. The carry chain is combinational across all digits in one cycle.
- All digits at 9 -> all digits 0, and wrap = 1 in that same output cycle.

Down (up_dn=0):
- Digit 0 decrements.
- A digit at 0 becomes 9 and borrows from the next digit.
- All digits at 0 -> all digits 9, and wrap = 1.

Output timing:
- count reflects the new value on the edge that samples en. There is no extra pipeline stage.
- wrap is a registered pulse coincident with the wrapped count. It is deasserted on any cycle that does not wrap, including hold cycles.

Invariants and direction:
- Every digit of count is always 0..9; no state produces a non-BCD digit.
- Direction may change on any cycle; the step uses the up_dn value sampled on that edge.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined:
  - Counting up from all-9s holds at all-9s.
  - Counting down from all-0s holds at 0.
  - wrap is asserted for one cycle on each attempted step past the limit, indicating saturation. count never wraps.
  - Load, clear and load_err behaviour are unchanged.
- Undefined: modular wrap as described under Behaviour.

Test Plan:
- Reset: DIGITS=2, drive arbitrary state, clear=1 with load=1, en=1 -> next cycle count=8'h00, wrap=0, load_err=0.
- Up carry/wrap: load 8'h08, en=1, up_dn=1 for 3 clocks -> count 8'h09, 8'h10, 8'h11. Then load 8'h99 and step once -> count=8'h00 with wrap=1 for exactly one cycle. With BCD_SATURATE_EN -> count=8'h99 with wrap=1.
- Down borrow/wrap: load 8'h10, up_dn=0, step -> 8'h09. Load 8'h00 and step -> 8'h99 with wrap=1. With BCD_SATURATE_EN -> stays 8'h00 with wrap=1.
- Invalid load: load_val=8'h3C -> count=8'h30 and load_err=1. A subsequent valid load keeps load_err=1; clear returns it to 0.
- Priority/hold: load=1 and en=1 together -> loaded value, no step. en=0 for 5 clocks -> count stable, wrap=0.
- Direction toggle: from 8'h50, alternate up_dn each clock with en=1 -> count 8'h51, 8'h50, 8'h51, 8'h50. Randomised 2000-cycle run checks against a decimal reference model and confirms every digit stays <=9.

Source files
------------

// File: rtl/bcd_counter_ndigit_if.sv
// Control and status bundle for the N-digit BCD counter.
// master drives the strobes and load value; slave (the counter) returns count/status.
interface bcd_counter_ndigit_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic                  load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, wrap, load_err
  );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// DIGITS-wide cascaded BCD counter with enable, direction, validated parallel load and wrap pulse.
// Optional macro BCD_SATURATE_EN: count holds at the limits instead of wrapping (wrap still pulses).
module bcd_counter_ndigit #(
  parameter int DIGITS = 4
) (
  input logic                 clock,
  input logic                 clear,
  bcd_counter_ndigit_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q;
  logic         wrap_q;
  logic         err_q;

  logic [W-1:0] step_val;
  logic [W-1:0] load_clean;
  logic         chain;
  logic         load_bad;
  logic [3:0]   dig;
  logic [3:0]   ldig;

  // chain starts as the unit step; it survives past the top digit only when every digit was at the limit
  always_comb begin
    step_val = count_q;
    chain    = 1'b1;
    dig      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = count_q[4*k +: 4];
      if (chain) begin
        if (bus.up_dn) begin
          if (dig == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = dig + 4'd1;
            chain              = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = dig - 4'd1;
            chain              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clean = '0;
    load_bad   = 1'b0;
    ldig       = '0;
    for (int k = 0; k < DIGITS; k++) begin
      ldig = bus.load_val[4*k +: 4];
      if (ldig > 4'd9) begin
        load_clean[4*k +: 4] = 4'd0;
        load_bad             = 1'b1;
      end else begin
        load_clean[4*k +: 4] = ldig;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clean;
      wrap_q  <= 1'b0;
      err_q   <= err_q | load_bad;
    end else if (bus.en) begin
`ifdef BCD_SATURATE_EN
      if (!chain) begin
        count_q <= step_val;
      end
`else
      count_q <= step_val;
`endif
      wrap_q  <= chain;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit (DIGITS=2): directed steps then a random run vs a decimal model.
module tb_bcd_counter_ndigit;
  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         err;
    string        tag;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_val = 0;
  logic m_err = 1'b0;
  logic m_wrap = 1'b0;
  int   m_max;
  exp_t sb[$];

  bcd_counter_ndigit_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter_ndigit #(.DIGITS(DIGITS)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic c, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic ud);
    int v;
    int mul;
    logic [3:0] d;
    if (c) begin
      m_val = 0; m_wrap = 1'b0; m_err = 1'b0;
    end else if (ld) begin
      v = 0; mul = 1;
      for (int k = 0; k < DIGITS; k++) begin
        d = lv[4*k +: 4];
        if (d > 4'd9) m_err = 1'b1;
        else v += int'(d) * mul;
        mul *= 10;
      end
      m_val = v; m_wrap = 1'b0;
    end else if (e) begin
      m_wrap = 1'b0;
      if (ud) begin
        if (m_val == m_max) begin
          m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
          m_val = 0;
`endif
        end else m_val++;
      end else begin
        if (m_val == 0) begin
          m_wrap = 1'b1;
`ifndef BCD_SATURATE_EN
          m_val = m_max;
`endif
        end else m_val--;
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic step(input logic c, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic ud, input string tag);
    exp_t x;
    exp_t p;
    clear = c; bus.load = ld; bus.load_val = lv; bus.en = e; bus.up_dn = ud;
    model(c, ld, lv, e, ud);
    x.count = to_bcd(m_val); x.wrap = m_wrap; x.err = m_err; x.tag = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    p = sb.pop_front();
    n_cmp++;
    assert (bus.count === p.count) else begin
      n_bad++;
      $error("FAIL %s count obs=%h exp=%h", p.tag, bus.count, p.count);
    end
    n_cmp++;
    assert (bus.wrap === p.wrap) else begin
      n_bad++;
      $error("FAIL %s wrap obs=%b exp=%b", p.tag, bus.wrap, p.wrap);
    end
    n_cmp++;
    assert (bus.load_err === p.err) else begin
      n_bad++;
      $error("FAIL %s load_err obs=%b exp=%b", p.tag, bus.load_err, p.err);
    end
    for (int k = 0; k < DIGITS; k++) begin
      n_cmp++;
      assert (bus.count[4*k +: 4] <= 4'd9) else begin
        n_bad++;
        $error("FAIL %s digit%0d obs=%h exp=<=9", p.tag, k, bus.count[4*k +: 4]);
      end
    end
  endtask

  initial begin
    m_max = 1;
    for (int k = 0; k < DIGITS; k++) m_max *= 10;
    m_max -= 1;
    clear = 1'b0; bus.en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0;

    // arbitrary state, then clear overriding load and en
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "init_clear");
    step(1'b0, 1'b1, 8'h4F, 1'b0, 1'b1, "arb_load");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "arb_step");
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, "reset");

    // up carry and wrap
    step(1'b0, 1'b1, 8'h08, 1'b0, 1'b1, "load_08");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "up_09");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "up_10");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "up_11");
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, "load_99");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "up_wrap");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "wrap_drop");

    // down borrow and wrap
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, "load_10");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "dn_09");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "load_00");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "dn_wrap");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "dn_after");

    // invalid load, sticky error, clear
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, "bad_load");
    step(1'b0, 1'b1, 8'h42, 1'b0, 1'b1, "good_load");
    step(1'b0, 1'b1, 8'hA7, 1'b0, 1'b1, "bad_hi");
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "err_clear");

    // load beats en, then hold
    step(1'b0, 1'b1, 8'h63, 1'b1, 1'b1, "load_pri");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "hold");

    // direction toggle
    step(1'b0, 1'b1, 8'h50, 1'b0, 1'b1, "load_50");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "tog_51");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "tog_50");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "tog_51b");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "tog_50b");

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           W'($urandom),
           $urandom_range(0, 3) != 0,
           1'($urandom),
           "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
